// File: rtl/encoder_pkg.sv
// Shared types and constants for the sequential 8-to-3 priority encoder.
//   N_REQ   : number of request lines (only 8 is supported)
//   CODE_W  : width of the encoded index, clog2(N_REQ)
//   req_t   : request / pending vector type
//   code_t  : encoded index type
//   state_t : output handshake state (IDLE = no code presented, HOLD = code valid)
package encoder_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned CODE_W = $clog2(N_REQ);

    typedef logic [N_REQ-1:0]  req_t;
    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One-hot mask for an encoded index.
    function automatic req_t code_to_mask(input code_t c);
        return req_t'(1) << c;
    endfunction

endpackage

// File: rtl/prio_enc_8to3.sv
// Combinational 8-to-3 priority encoder, highest index wins.
//   in_bits : request vector
//   idx     : index of the highest set bit (0 when in_bits is 0)
//   any     : at least one bit of in_bits is set
module prio_enc_8to3
    import encoder_pkg::*;
(
    input  req_t  in_bits,
    output code_t idx,
    output logic  any
);

    // Ascending scan: later (higher) set bits overwrite lower ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in_bits[i]) begin
                idx = code_t'(i);
            end
        end
    end

    assign any = |in_bits;

endmodule

// File: rtl/encoder_8to3_seq.sv
// Registered 8-to-3 priority encoder with sticky request capture and a
// valid/ready output handshake. Requests accumulate in a pending register and
// are issued one index per accepted transfer, highest index first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   en    : capture enable for req
//   req   : request lines, req[i] <-> decoder output Yi
//   code  : encoded index, qualified by valid (holds last value when idle)
//   valid : code is presented
//   ready : consumer accepts code when valid && ready
//   pend  : captured requests not yet issued
//   dup   : one-cycle pulse, a request hit a bit that was already pending
module encoder_8to3_seq
    import encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic [N_REQ-1:0]  pend,
    output logic              dup
);

    state_t state_q, state_d;
    req_t   pend_q, pend_d;
    code_t  code_q, code_d;
    logic   dup_q, dup_d;

    code_t  top_idx;
    logic   pend_any;
    logic   load;
    req_t   load_mask;
    req_t   req_gated;

    prio_enc_8to3 u_prio (
        .in_bits (pend_q),
        .idx     (top_idx),
        .any     (pend_any)
    );

    assign req_gated = en ? req : '0;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        load      = 1'b0;
        load_mask = '0;

        unique case (state_q)
            IDLE: begin
                if (pend_any) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (pend_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            code_d    = top_idx;
            load_mask = code_to_mask(top_idx);
        end

        // A new request on the bit being loaded re-sets it, so it is issued again.
        pend_d = (pend_q & ~load_mask) | req_gated;
        dup_d  = |(req_gated & pend_q & ~load_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            dup_q   <= dup_d;
        end
    end

    assign code  = code_q;
    assign valid = (state_q == HOLD);
    assign pend  = pend_q;
    assign dup   = dup_q;

endmodule
